// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH runtime-programmable integer clock dividers with tick strobes and lock flags.
// Divisor and enable changes only take effect at a period boundary, so the divided clocks never glitch.
module clk_div_bank #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 8,
    parameter int LOCK_CNT  = 16,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LW = $clog2(LOCK_CNT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    input  logic [CW-1:0]        cfg_ch_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    output logic                 cfg_ready_o,
    input  logic [NUM_CH-1:0]    en_i,
    output logic [NUM_CH-1:0]    clk_o,
    output logic [NUM_CH-1:0]    tick_o,
    output logic [NUM_CH-1:0]    locked_o
);
    logic              ready_en;
    logic [NUM_CH-1:0] pend_full;

    always_ff @(posedge clk_i) ready_en <= !rst_i;

    // Writes to a channel number beyond NUM_CH are accepted and dropped.
    assign cfg_ready_o = ready_en & ((32'(cfg_ch_i) >= NUM_CH) | ~pend_full[cfg_ch_i]);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_WIDTH-1:0] div, pend_div, cnt, new_div;
        logic [DIV_WIDTH:0]   per, high;
        logic [LW-1:0]        lock;
        logic                 full, run, clk_q, tick_q;
        logic                 boundary, apply, go, accept;

        always_comb begin
            per      = (div < DIV_WIDTH'(2)) ? (DIV_WIDTH+1)'(2) : {1'b0, div};
            high     = (per + 1'b1) >> 1;
            boundary = run && ({1'b0, cnt} == per - 1'b1);
            apply    = full && (boundary || !run);
            new_div  = apply ? pend_div : div;
            go       = en_i[c] && (new_div != '0);
            accept   = cfg_valid_i && cfg_ready_o && (32'(cfg_ch_i) == c);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                div      <= '0;
                pend_div <= '0;
                full     <= 1'b0;
                run      <= 1'b0;
                cnt      <= '0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
                lock     <= '0;
            end else begin
                if (apply) begin
                    div  <= pend_div;
                    full <= 1'b0;
                end
                // The slot can only be filled while empty, so this never races the apply above.
                if (accept) begin
                    pend_div <= cfg_div_i;
                    full     <= 1'b1;
                end
                if (!run || boundary) begin
                    run    <= go;
                    cnt    <= '0;
                    clk_q  <= go;
                    tick_q <= go;
                    lock   <= (!run || !go || (apply && pend_div != div)) ? '0 :
                              (lock == LW'(LOCK_CNT)) ? lock : lock + 1'b1;
                end else begin
                    cnt    <= cnt + 1'b1;
                    clk_q  <= ({1'b0, cnt} + 1'b1) < high;
                    tick_q <= 1'b0;
                end
            end
        end

        assign pend_full[c] = full;
        assign clk_o[c]     = clk_q;
        assign tick_o[c]    = tick_q;
        assign locked_o[c]  = (lock == LW'(LOCK_CNT));
    end
endmodule
